// File: rtl/multi_lane_delay_histogram_if.sv
// Histogram record stream: one (lane, tap, error count) record per handshake.
// The producer holds lane/tap/count stable while valid is high and ready is low.
interface multi_lane_delay_histogram_if #(
    parameter int LANES = 4,
    parameter int TAPS  = 32,
    parameter int CNT_W = 16
);
    localparam int TAP_W  = $clog2(TAPS);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic              valid;
    logic              ready;
    logic [LANE_W-1:0] lane;
    logic [TAP_W-1:0]  tap;
    logic [CNT_W-1:0]  count;

    modport master (output valid, lane, tap, count, input ready);
    modport slave  (input valid, lane, tap, count, output ready);
endinterface

// File: rtl/multi_lane_delay_histogram.sv
// Multi-lane delay-tap sweep with per-lane bit-error histogram.
// Steps every delay tap, lets the delay line settle, counts bit errors against
// the shared expected pattern for a fixed window, then streams one record per
// lane out through the record interface.
// Optional best-tap tracking: define MULTI_LANE_DELAY_HISTOGRAM_BEST_TAP_EN.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; busy low
// LOAD   | one-cycle load strobe of the current tap, error counters cleared
// SETTLE | delay elements settling, inputs ignored
// COUNT  | accumulate per-lane popcount(data ^ expected) every cycle
// DUMP   | stream one record per lane, advancing on handshake
// FIN    | one-cycle done pulse, back to IDLE
module multi_lane_delay_histogram #(
    parameter int LANES  = 4,
    parameter int WIDTH  = 8,
    parameter int TAPS   = 32,
    parameter int WINDOW = 1024,
    parameter int SETTLE = 16,
    parameter int CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         dly_ld,
    output logic [$clog2(TAPS)-1:0]      dly_tap,
    input  logic [LANES*WIDTH-1:0]       dat,
    input  logic [WIDTH-1:0]             exp_pat,
    multi_lane_delay_histogram_if.master rec,
    output logic [LANES*$clog2(TAPS)-1:0] best_tap
);
    localparam int TAP_W  = $clog2(TAPS);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PC_W   = $clog2(WIDTH + 1);
    localparam int SUM_W  = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam int TMAX   = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TIM_W  = $clog2(TMAX + 1);

    localparam logic [TAP_W-1:0]  LAST_TAP  = TAP_W'(TAPS - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_COUNT,
        S_DUMP,
        S_FIN
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [TAP_W-1:0]   tap;
    logic [LANE_W-1:0]  lane;
    logic [TIM_W-1:0]   timer;
    logic               tc;
    logic               hs;
    logic [CNT_W-1:0]   cnt     [LANES];
    logic [CNT_W-1:0]   cnt_add [LANES];
    logic [SUM_W-1:0]   sum     [LANES];
    logic [CNT_W-1:0]   cur_count;
    logic [1:0]         rst_sync;
    logic               rst_int_n;

    function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) n = n + PC_W'(v[i]);
        return n;
    endfunction

    // Reset asserts asynchronously but releases only on a clean clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    assign tc        = (timer == '0);
    assign hs        = rec.valid && rec.ready;
    assign cur_count = cnt[lane];

    assign dly_tap   = tap;
    assign rec.lane  = lane;
    assign rec.tap   = tap;
    assign rec.count = cur_count;

    // Next-state decode and state-driven outputs.
    always_comb begin
        next_state = state;
        busy       = (state != S_IDLE);
        done       = (state == S_FIN);
        dly_ld     = (state == S_LOAD);
        rec.valid  = (state == S_DUMP);
        case (state)
            S_IDLE:   if (start) next_state = S_LOAD;
            S_LOAD:   next_state = S_SETTLE;
            S_SETTLE: if (tc) next_state = S_COUNT;
            S_COUNT:  if (tc) next_state = S_DUMP;
            S_DUMP:   if (hs && lane == LAST_LANE)
                          next_state = (tap == LAST_TAP) ? S_FIN : S_LOAD;
            S_FIN:    next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // State register, tap/lane pointers and the settle/window down-counter.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state <= S_IDLE;
            tap   <= '0;
            lane  <= '0;
            timer <= '0;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE:   if (start) tap <= '0;
                S_LOAD: begin
                    lane  <= '0;
                    timer <= TIM_W'(SETTLE - 1);
                end
                S_SETTLE: timer <= tc ? TIM_W'(WINDOW - 1) : timer - 1'b1;
                S_COUNT:  if (!tc) timer <= timer - 1'b1;
                S_DUMP: begin
                    if (hs) begin
                        if (lane == LAST_LANE) begin
                            lane <= '0;
                            if (tap != LAST_TAP) tap <= tap + 1'b1;
                        end else begin
                            lane <= lane + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating per-lane error sums; the extra sum bit catches overflow.
    always_comb begin
        for (int n = 0; n < LANES; n++) begin
            sum[n]     = '0;
            cnt_add[n] = '0;
        end
        for (int n = 0; n < LANES; n++) begin
            sum[n] = SUM_W'(cnt[n]) + SUM_W'(popcount(dat[n*WIDTH +: WIDTH] ^ exp_pat));
            cnt_add[n] = (sum[n] > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[n][CNT_W-1:0];
        end
    end

    // Error counters: cleared on each tap load, accumulate only in COUNT.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            cnt <= '{default: '0};
        end else if (state == S_LOAD) begin
            cnt <= '{default: '0};
        end else if (state == S_COUNT) begin
            for (int n = 0; n < LANES; n++) cnt[n] <= cnt_add[n];
        end
    end

`ifdef MULTI_LANE_DELAY_HISTOGRAM_BEST_TAP_EN
    logic [CNT_W-1:0]       min_cnt     [LANES];
    logic [TAP_W-1:0]       min_tap     [LANES];
    logic [TAP_W-1:0]       min_tap_nxt [LANES];
    logic [LANES-1:0]       take;
    logic [LANES*TAP_W-1:0] best_r;

    // A record replaces the lane minimum only when strictly lower, so ties keep the earlier tap.
    always_comb begin
        take = '0;
        for (int n = 0; n < LANES; n++) min_tap_nxt[n] = '0;
        for (int n = 0; n < LANES; n++) begin
            take[n]        = hs && (lane == LANE_W'(n)) && (cur_count < min_cnt[n]);
            min_tap_nxt[n] = take[n] ? tap : min_tap[n];
        end
    end

    // Per-lane minimum trackers, re-armed at the first tap of each sweep.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            min_cnt <= '{default: '0};
            min_tap <= '{default: '0};
        end else if (state == S_LOAD && tap == '0) begin
            min_cnt <= '{default: '1};
            min_tap <= '{default: '0};
        end else begin
            for (int n = 0; n < LANES; n++) begin
                if (take[n]) begin
                    min_cnt[n] <= cur_count;
                    min_tap[n] <= tap;
                end
            end
        end
    end

    // Publish the result as FIN is entered, including the final record's update.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            best_r <= '0;
        end else if (next_state == S_FIN) begin
            for (int n = 0; n < LANES; n++) best_r[n*TAP_W +: TAP_W] <= min_tap_nxt[n];
        end
    end

    assign best_tap = best_r;
`else
    assign best_tap = '0;
`endif

endmodule

// File: tb/tb_multi_lane_delay_histogram.sv
// Self-checking bench for multi_lane_delay_histogram.
// The reference model records every driven input by cycle, locates each COUNT
// window from the observed load strobe and the fixed settle/window lengths, and
// sums error bits directly. Honours MULTI_LANE_DELAY_HISTOGRAM_BEST_TAP_EN.
module tb_multi_lane_delay_histogram;
    localparam int LANES  = 2;
    localparam int WIDTH  = 8;
    localparam int TAPS   = 4;
    localparam int WINDOW = 8;
    localparam int SETTLE = 2;
    localparam int CNT_W  = 4;
    localparam int TAP_W  = $clog2(TAPS);
    localparam int HMAX   = 8192;
    localparam int CMAX   = (1 << CNT_W) - 1;
    // start cycle and done cycle both counted
    localparam int SWEEP_CYC = TAPS * (1 + SETTLE + WINDOW + LANES) + 1 + 1;

    typedef enum int {M_CONST, M_RAND, M_BEST} mode_t;
    typedef struct { int f0; int f1; int c0; int c1; } vec_t;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start;
    logic                     busy;
    logic                     done;
    logic                     dly_ld;
    logic [TAP_W-1:0]         dly_tap;
    logic [LANES*WIDTH-1:0]   dat;
    logic [WIDTH-1:0]         exp_pat;
    logic [LANES*TAP_W-1:0]   best_tap;

    multi_lane_delay_histogram_if #(.LANES(LANES), .TAPS(TAPS), .CNT_W(CNT_W)) rec ();

    multi_lane_delay_histogram #(
        .LANES(LANES), .WIDTH(WIDTH), .TAPS(TAPS),
        .WINDOW(WINDOW), .SETTLE(SETTLE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .dly_ld(dly_ld), .dly_tap(dly_tap), .dat(dat), .exp_pat(exp_pat),
        .rec(rec), .best_tap(best_tap)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;
    logic [LANES*WIDTH-1:0] dat_h [HMAX];
    logic [WIDTH-1:0]       exp_h [HMAX];

    int ld_k, nxt_tap, cur_tap, m_lane, n_ld, n_rec, n_done, n_wait, n_hold;
    int start_cyc, done_cyc, stall_left;
    int bt_cnt [LANES];
    int bt_tap [LANES];
    int pat [TAPS] = '{5, 2, 2, 7};
    mode_t mode;
    int f0, f1, c0, c1, rdy_mode;
    bit start_req, prev_stall;
    int hold_lane, hold_tap, hold_count;

    task automatic chk(input string name, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, want, ncyc);
        end
    endtask

    function automatic int model_count(input int l);
        int s;
        logic [LANES*WIDTH-1:0] d;
        logic [WIDTH-1:0] e;
        s = 0;
        for (int j = ld_k + SETTLE + 1; j <= ld_k + SETTLE + WINDOW; j++) begin
            d = dat_h[j % HMAX];
            e = exp_h[j % HMAX];
            s += $countones(d[l*WIDTH +: WIDTH] ^ e);
        end
        return (s > CMAX) ? CMAX : s;
    endfunction

    task automatic model_reset();
        nxt_tap = 0; cur_tap = 0; m_lane = 0; n_ld = 0; n_rec = 0;
        n_wait = 0; n_hold = 0; ld_k = -1000; stall_left = 5; prev_stall = 0;
        for (int l = 0; l < LANES; l++) begin
            bt_cnt[l] = CMAX + 1;
            bt_tap[l] = 0;
        end
    endtask

    // One clock: observe at the falling edge, check, then drive next inputs.
    task automatic tick();
        logic [WIDTH-1:0] e, m;
        logic [LANES*WIDTH-1:0] d;
        int want;
        @(negedge clk);
        ncyc++;
        if (dly_ld) begin
            chk("ld_tap", dly_tap, nxt_tap);
            cur_tap = nxt_tap; nxt_tap++; ld_k = ncyc; m_lane = 0; n_ld++;
        end
        if (done) begin
            n_done++;
            done_cyc = ncyc;
        end
        if (prev_stall) begin
            chk("hold_valid", rec.valid, 1);
            chk("hold_lane", rec.lane, hold_lane);
            chk("hold_tap", rec.tap, hold_tap);
            chk("hold_count", rec.count, hold_count);
            if (rdy_mode == 2) n_hold++;
        end
        case (rdy_mode)
            0: rec.ready = 1'b1;
            1: rec.ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (rec.valid && cur_tap == 2 && m_lane == 0 && stall_left > 0) begin
                    rec.ready = 1'b0;
                    stall_left--;
                end else begin
                    rec.ready = 1'b1;
                end
            end
        endcase
        if (rec.valid && rec.ready) begin
            want = model_count(m_lane);
            chk("rec_lane", rec.lane, m_lane);
            chk("rec_tap", rec.tap, cur_tap);
            chk("rec_count", rec.count, want);
            if (mode == M_CONST) chk("tbl_count", rec.count, (m_lane == 0) ? c0 : c1);
            if (m_lane < LANES && want < bt_cnt[m_lane]) begin
                bt_cnt[m_lane] = want;
                bt_tap[m_lane] = cur_tap;
            end
            m_lane++; n_rec++;
        end
        if (rec.valid && !rec.ready) n_wait++;
        prev_stall = rec.valid && !rec.ready;
        hold_lane  = int'(rec.lane);
        hold_tap   = int'(rec.tap);
        hold_count = int'(rec.count);

        start = start_req;
        if (start_req) start_cyc = ncyc;
        start_req = 0;
        e = WIDTH'($urandom);
        d = '0;
        for (int l = 0; l < LANES; l++) begin
            case (mode)
                M_CONST: m = WIDTH'((1 << ((l == 0) ? f0 : f1)) - 1);
                M_RAND:  m = WIDTH'($urandom) & WIDTH'($urandom) & WIDTH'($urandom);
                default: m = (l == 0 && ncyc == ld_k + SETTLE + 1) ?
                             WIDTH'((1 << pat[cur_tap]) - 1) : '0;
            endcase
            d[l*WIDTH +: WIDTH] = e ^ m;
        end
        dat = d;
        exp_pat = e;
        dat_h[ncyc % HMAX] = d;
        exp_h[ncyc % HMAX] = e;
    endtask

    task automatic sweep(input string tag);
        int d0;
        logic [LANES*TAP_W-1:0] want_bt;
        model_reset();
        d0 = n_done;
        start_req = 1;
        for (int i = 0; i < 2000 && n_done == d0; i++) tick();
        chk({tag, ":done_once"}, n_done - d0, 1);
        chk({tag, ":ld_count"}, n_ld, TAPS);
        chk({tag, ":rec_count"}, n_rec, TAPS * LANES);
        chk({tag, ":latency"}, done_cyc - start_cyc + 1, SWEEP_CYC + n_wait);
        tick();
        chk({tag, ":busy_after"}, busy, 0);
        chk({tag, ":done_pulse"}, done, 0);
        want_bt = '0;
`ifdef MULTI_LANE_DELAY_HISTOGRAM_BEST_TAP_EN
        for (int l = 0; l < LANES; l++) want_bt[l*TAP_W +: TAP_W] = TAP_W'(bt_tap[l]);
`endif
        chk({tag, ":best_tap"}, best_tap, want_bt);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ":busy"}, busy, 0);
        chk({tag, ":done"}, done, 0);
        chk({tag, ":dly_ld"}, dly_ld, 0);
        chk({tag, ":dly_tap"}, dly_tap, 0);
        chk({tag, ":valid"}, rec.valid, 0);
        chk({tag, ":lane"}, rec.lane, 0);
        chk({tag, ":tap"}, rec.tap, 0);
        chk({tag, ":count"}, rec.count, 0);
        chk({tag, ":best_tap"}, best_tap, 0);
    endtask

    initial begin
        vec_t tbl [5];
        int d0;
        tbl = '{'{0, 0, 0, 0}, '{0, 1, 0, 8}, '{8, 8, 15, 15}, '{1, 0, 8, 0}, '{3, 1, 15, 8}};

        rst_n = 0; start = 0; dat = '0; exp_pat = '0; rec.ready = 1'b1;
        start_req = 0; mode = M_CONST; rdy_mode = 0; n_done = 0;
        f0 = 0; f1 = 0; c0 = 0; c1 = 0; start_cyc = 0; done_cyc = 0;
        model_reset();
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1;
        repeat (4) tick();
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 5; i++) begin
            mode = M_CONST;
            f0 = tbl[i].f0; f1 = tbl[i].f1; c0 = tbl[i].c0; c1 = tbl[i].c1;
            sweep($sformatf("tbl%0d", i));
        end

        mode = M_BEST;
        sweep("best");
`ifdef MULTI_LANE_DELAY_HISTOGRAM_BEST_TAP_EN
        chk("best_lane0", best_tap[TAP_W-1:0], 1);
`else
        chk("best_off", best_tap, 0);
`endif

        mode = M_CONST; f0 = 1; f1 = 2; c0 = 8; c1 = 15; rdy_mode = 2;
        sweep("stall");
        chk("stall_hold_cycles", n_hold, 5);

        mode = M_RAND; rdy_mode = 1;
        for (int i = 0; i < 8; i++) sweep($sformatf("rand%0d", i));

        // start during COUNT of tap 1, then reset mid-sweep
        mode = M_CONST; f0 = 1; f1 = 1; c0 = 8; c1 = 8; rdy_mode = 0;
        model_reset();
        d0 = n_done;
        start_req = 1;
        for (int i = 0; i < 200 && !(n_ld == 2 && ncyc >= ld_k + SETTLE + 3); i++) tick();
        chk("reach_tap1", n_ld, 2);
        start_req = 1;
        tick();
        tick();
        chk("start_ignored_ld", dly_ld, 0);
        chk("start_ignored_busy", busy, 1);
        chk("pre_reset_tap", dly_tap, 1);
        tick();
        #2 rst_n = 0;
        #1 chk_all_zero("mid_reset");
        repeat (3) @(negedge clk);
        chk_all_zero("held_reset");
        rst_n = 1;
        repeat (5) tick();
        chk("no_done_after_abort", n_done - d0, 0);
        chk("idle_after_abort", busy, 0);
        sweep("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multi_lane_delay_histogram.md
MULTI_LANE_DELAY_HISTOGRAM -- requirements
Module: multi_lane_delay_histogram

Interface
REQ-001 The block SHALL have parameter LANES, default 4: number of independent data lanes.
REQ-002 The block SHALL have parameter WIDTH, default 8: deserialised bits per lane per cycle.
REQ-003 The block SHALL have parameter TAPS, default 32: delay taps swept, 0..TAPS-1; tap port width TAP_W = $clog2(TAPS).
REQ-004 The block SHALL have parameter WINDOW, default 1024: compare cycles per tap.
REQ-005 The block SHALL have parameter SETTLE, default 16: idle cycles after a tap load before counting.
REQ-006 The block SHALL have parameter CNT_W, default 16: error counter width.
REQ-007 The block SHALL have port CLK, input, 1: single clock; all logic on rising edge.
REQ-008 The block SHALL have port RST_N, input, 1: reset, asynchronous, active-low.
REQ-009 The block SHALL have port START, input, 1: one-cycle pulse that begins a sweep.
REQ-010 The block SHALL have port BUSY, output, 1: sweep in progress.
REQ-011 The block SHALL have port DONE, output, 1: one-cycle pulse at sweep end.
REQ-012 The block SHALL have port DLY_LD, output, 1: one-cycle load strobe to all lane delay elements.
REQ-013 The block SHALL have port DLY_TAP, output, TAP_W: tap value, valid while DLY_LD is high.
REQ-014 The block SHALL have port DAT_I, input, LANES*WIDTH: received data; lane n occupies bits [n*WIDTH +: WIDTH].
REQ-015 The block SHALL have port EXP_I, input, WIDTH: expected pattern, cycle-aligned with DAT_I, shared by all lanes.
REQ-016 The block SHALL have port OUT_VALID, input/output as follows: output, 1: histogram record valid.
REQ-017 The block SHALL have port OUT_READY, input, 1: consumer accepts the record when OUT_VALID and OUT_READY are both high.
REQ-018 The block SHALL have port OUT_LANE, output, $clog2(LANES) (minimum 1): record lane index.
REQ-019 The block SHALL have port OUT_TAP, output, TAP_W: record tap.
REQ-020 The block SHALL have port OUT_COUNT, output, CNT_W: record error count.
REQ-021 The block SHALL have port BEST_TAP, output, LANES*TAP_W: per-lane minimum-error tap (see Configuration).

Function
REQ-022 The FSM SHALL have the states IDLE, LOAD, SETTLE, COUNT, DUMP and FIN.
REQ-023 IDLE: on START, the tap SHALL be set to 0 and the FSM SHALL go to LOAD. START SHALL be ignored in every other state.
REQ-024 LOAD (1 cycle): DLY_LD=1 and DLY_TAP=current tap; the per-lane counters SHALL be cleared; the next state SHALL be SETTLE.
REQ-025 SETTLE SHALL last exactly SETTLE cycles, then go to COUNT.
REQ-026 COUNT SHALL last exactly WINDOW cycles. In each of these cycles, lane n's counter SHALL add popcount(DAT_I lane n XOR EXP_I), sampled that same cycle.
REQ-027 Counter addition SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-028 DUMP SHALL emit LANES records in lane order 0..LANES-1, with OUT_TAP equal to the current tap.
REQ-029 During DUMP, a record SHALL advance only on OUT_VALID&&OUT_READY.
REQ-030 While OUT_VALID is high and OUT_READY is low, OUT_LANE, OUT_TAP and OUT_COUNT SHALL hold stable.
REQ-031 After the last record of a tap, the FSM SHALL go to LOAD with tap+1 if tap<TAPS-1; otherwise it SHALL go to FIN.
REQ-032 FIN (1 cycle) SHALL assert DONE and then return to IDLE.
REQ-033 BUSY SHALL be 1 in every state except IDLE.
REQ-034 DAT_I and EXP_I SHALL be ignored outside COUNT.
REQ-035 The latency from START to the first DLY_LD SHALL be 1 cycle.

Reset
REQ-036 RST_N low SHALL asynchronously force: FSM=IDLE, tap=0, all counters=0, BUSY=0, DONE=0, DLY_LD=0, DLY_TAP=0, OUT_VALID=0, OUT_LANE=0, OUT_TAP=0, OUT_COUNT=0, BEST_TAP=0.
REQ-037 Reset asserted mid-sweep SHALL abort the sweep with no DONE pulse. An in-flight record SHALL be dropped.
REQ-038 Reset release SHALL be synchronised internally (two-flop) so that the FSM leaves reset on a clean CLK edge.

Configuration
REQ-039 Macro MULTI_LANE_DELAY_HISTOGRAM_BEST_TAP_EN SHALL control best-tap tracking.
REQ-040 When MULTI_LANE_DELAY_HISTOGRAM_BEST_TAP_EN is defined:
- per lane, a tracker SHALL hold the minimum count and its tap;
- the tracker SHALL update at each record handshake when the count is strictly less than the stored minimum (ties keep the lower tap);
- the minimum SHALL initialise to all-ones at LOAD of tap 0;
- BEST_TAP SHALL update on the cycle FIN is entered and hold until the next FIN or reset.
REQ-041 When MULTI_LANE_DELAY_HISTOGRAM_BEST_TAP_EN is undefined, BEST_TAP SHALL be constant 0 and no tracking logic SHALL be synthesised.

Verification
REQ-042 LANES=2, TAPS=4, WINDOW=8, SETTLE=2, DAT_I==EXP_I always, OUT_READY=1 -> DLY_LD at taps 0,1,2,3; 8 records, all OUT_COUNT=0; DONE once; START-to-DONE exactly 4*(1+2+8+2)+1+1 cycles.
REQ-043 Lane 1 with 1 bit flipped every COUNT cycle, WINDOW=8 -> lane 1 records =8, lane 0 records =0.
REQ-044 CNT_W=4, all 8 bits wrong, WINDOW=8 -> OUT_COUNT=15 (saturated), not 0.
REQ-045 OUT_READY held low 5 cycles on the lane-0 record of tap 2 -> record fields stable for those 5 cycles; no counting starts; the sweep resumes and DONE still occurs.
REQ-046 START during COUNT -> ignored; RST_N pulsed low during tap 1 -> all outputs 0 immediately, no DONE; a new START afterwards sweeps from tap 0.
REQ-047 BEST_TAP_EN defined, lane 0 errors 5,2,2,7 over taps 0..3 -> BEST_TAP lane 0 =1 after DONE; BEST_TAP_EN undefined -> BEST_TAP=0.
